// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage
// Brief    : MEM pipeline stage with one outstanding data-memory access and
//            the MEM/WB register. Optional macro MEMORY_STAGE_TIMEOUT_EN adds
//            a WAIT-cycle timeout that aborts a hung access.
// Revision : 1.0 - initial release
// ============================================================================
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  WB_in,
  input  logic [2:0]  MEM_in,
  input  logic [4:0]  RD_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] WriteData_in,
  input  logic        valid_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [1:0]  WB_out,
  output logic [4:0]  RD_out,
  output logic [31:0] ALU_out,
  output logic [31:0] ReadData_out,
  output logic        valid_out,
  output logic        timeout_err
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;

  // Instruction held while the memory access is outstanding
  logic [1:0]  wb_lat_q, wb_lat_d;
  logic [4:0]  rd_lat_q, rd_lat_d;
  logic [31:0] alu_lat_q, alu_lat_d;
  logic        read_lat_q, read_lat_d;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [1:0]  wb_out_q, wb_out_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] rdata_out_q, rdata_out_d;
  logic        valid_out_q, valid_out_d;

  logic        w_mem_op;
  logic        w_idle;
  logic        w_wait;
  logic        w_accept_alu;
  logic        w_accept_mem;
  logic        w_ack;
  logic        w_abort;
  logic        w_unused;

  assign w_mem_op     = MEM_in[1] | MEM_in[0];
  assign w_idle       = (state_q == c_IDLE);
  assign w_wait       = (state_q == c_WAIT);
  assign w_accept_alu = w_idle & valid_in & ~w_mem_op;
  assign w_accept_mem = w_idle & valid_in & w_mem_op;
  assign w_ack        = w_wait & dmem_ack;

`ifdef MEMORY_STAGE_TIMEOUT_EN
  localparam logic [7:0] c_TIMEOUT = TIMEOUT_CYCLES[7:0];

  logic [7:0] cnt_q, cnt_d;
  logic       tout_q;

  // An ack in the terminal-count cycle still completes normally
  assign w_abort = w_wait & ~dmem_ack & (cnt_q == c_TIMEOUT);

  always_comb begin
    cnt_d = cnt_q;
    if (w_accept_mem) begin
      cnt_d = 8'd0;
    end else if (w_wait && !dmem_ack && !w_abort) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 8'd0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= w_abort;
    end
  end

  assign timeout_err = tout_q;
  assign w_unused    = MEM_in[2];
`else
  assign w_abort     = 1'b0;
  assign timeout_err = 1'b0;
  assign w_unused    = MEM_in[2] ^ TIMEOUT_CYCLES[0];
`endif

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_IDLE;
      wb_lat_q    <= 2'b00;
      rd_lat_q    <= 5'd0;
      alu_lat_q   <= 32'd0;
      read_lat_q  <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wb_out_q    <= 2'b00;
      rd_out_q    <= 5'd0;
      alu_out_q   <= 32'd0;
      rdata_out_q <= 32'd0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_lat_q    <= wb_lat_d;
      rd_lat_q    <= rd_lat_d;
      alu_lat_q   <= alu_lat_d;
      read_lat_q  <= read_lat_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wb_out_q    <= wb_out_d;
      rd_out_q    <= rd_out_d;
      alu_out_q   <= alu_out_d;
      rdata_out_q <= rdata_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_accept_mem)      state_d = c_WAIT;
      c_WAIT:  if (w_ack || w_abort)  state_d = c_IDLE;
      default:                        state_d = c_IDLE;
    endcase
  end

  always_comb begin
    // The stall also drops in the abort cycle so upstream does not replay the op
    stall_out = ~rst & (w_accept_mem | (w_wait & ~dmem_ack & ~w_abort));

    wb_lat_d    = wb_lat_q;
    rd_lat_d    = rd_lat_q;
    alu_lat_d   = alu_lat_q;
    read_lat_d  = read_lat_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wb_out_d    = 2'b00;
    rd_out_d    = rd_out_q;
    alu_out_d   = alu_out_q;
    rdata_out_d = rdata_out_q;
    valid_out_d = 1'b0;

    if (w_accept_alu) begin
      wb_out_d    = WB_in;
      rd_out_d    = RD_in;
      alu_out_d   = ALU_in;
      rdata_out_d = 32'd0;
      valid_out_d = 1'b1;
    end

    if (w_accept_mem) begin
      wb_lat_d   = WB_in;
      rd_lat_d   = RD_in;
      alu_lat_d  = ALU_in;
      // Read+write together is treated as a write
      read_lat_d = MEM_in[1] & ~MEM_in[0];
      req_d      = 1'b1;
      we_d       = MEM_in[0];
      addr_d     = {ALU_in[31:2], 2'b00};
      wdata_d    = WriteData_in;
    end

    if (w_ack) begin
      wb_out_d    = wb_lat_q;
      rd_out_d    = rd_lat_q;
      alu_out_d   = alu_lat_q;
      rdata_out_d = read_lat_q ? dmem_rdata : 32'd0;
      valid_out_d = 1'b1;
      req_d       = 1'b0;
    end

    if (w_abort) begin
      wb_out_d    = {1'b0, wb_lat_q[0]};
      rd_out_d    = rd_lat_q;
      alu_out_d   = alu_lat_q;
      rdata_out_d = 32'd0;
      valid_out_d = 1'b1;
      req_d       = 1'b0;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign WB_out       = wb_out_q;
  assign RD_out       = rd_out_q;
  assign ALU_out      = alu_out_q;
  assign ReadData_out = rdata_out_q;
  assign valid_out    = valid_out_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_stage
// Brief    : Directed scoreboard bench for memory_stage (timeout cases run
//            only when MEMORY_STAGE_TIMEOUT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

`ifdef MEMORY_STAGE_TIMEOUT_EN
  localparam int c_TO = 4;
`else
  localparam int c_TO = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WB_in;
  logic [2:0]  MEM_in;
  logic [4:0]  RD_in;
  logic [31:0] ALU_in;
  logic [31:0] WriteData_in;
  logic        valid_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [1:0]  WB_out;
  logic [4:0]  RD_out;
  logic [31:0] ALU_out;
  logic [31:0] ReadData_out;
  logic        valid_out;
  logic        timeout_err;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(c_TO)) dut (
    .clk(clk), .rst(rst),
    .WB_in(WB_in), .MEM_in(MEM_in), .RD_in(RD_in), .ALU_in(ALU_in),
    .WriteData_in(WriteData_in), .valid_in(valid_in), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .WB_out(WB_out), .RD_out(RD_out), .ALU_out(ALU_out),
    .ReadData_out(ReadData_out), .valid_out(valid_out), .timeout_err(timeout_err)
  );

  typedef logic [70:0] rec_t;  // {WB, RD, ALU, ReadData}
  rec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every retire must match the oldest expected record
  always @(negedge clk) begin
    rec_t e;
    if (!rst && valid_out) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_retire: got %0h required no retire",
                 {WB_out, RD_out, ALU_out, ReadData_out});
      end else begin
        e = exp_q.pop_front();
        check("retire", {WB_out, RD_out, ALU_out, ReadData_out}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] mem,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
    valid_in     = v;
    WB_in        = wb;
    MEM_in       = mem;
    RD_in        = rd;
    ALU_in       = alu;
    WriteData_in = wd;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    rst = 1'b1;
    idle();
    dmem_rdata = 32'd0;
    dmem_ack   = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("reset_mem_wb", {WB_out, RD_out, ALU_out, ReadData_out}, 71'd0);
    check("reset_ctrl", {valid_out, dmem_req, dmem_we, timeout_err, stall_out}, 71'd0);
    check("reset_dmem", {dmem_addr, dmem_wdata}, 71'd0);
    tick();
    rst = 1'b0;

    // ADD: single-cycle retire, never stalls
    drive(1'b1, 2'b10, 3'b000, 5'd5, 32'h1234, 32'h0);
    exp_q.push_back({2'b10, 5'd5, 32'h1234, 32'h0});
    @(negedge clk);
    check("add_stall", stall_out, 1'b0);
    tick();
    idle();
    dmem_ack = 1'b1;  // stray ack in IDLE must be ignored
    @(negedge clk);
    check("add_valid", valid_out, 1'b1);
    check("idle_ack_stall", stall_out, 1'b0);
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("bubble_hold", {valid_out, WB_out, RD_out, ALU_out, dmem_req},
          {1'b0, 2'b00, 5'd5, 32'h1234, 1'b0});
    tick();

    // LOAD: unaligned address, ack after three empty WAIT cycles
    drive(1'b1, 2'b11, 3'b010, 5'd7, 32'h103, 32'h0);
    exp_q.push_back({2'b11, 5'd7, 32'h103, 32'hDEADBEEF});
    stalls = 0;
    @(negedge clk);
    if (stall_out) stalls++;
    tick();
    drive(1'b1, 2'b10, 3'b000, 5'd31, 32'hFFFF_FFF0, 32'h0);  // ignored while waiting
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (stall_out) stalls++;
      check("load_req", {dmem_req, dmem_we, dmem_addr, valid_out},
            {1'b1, 1'b0, 32'h100, 1'b0});
      tick();
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("load_ack_stall", stall_out, 1'b0);
    check("load_stall_cycles", 71'(stalls), 71'd4);
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    idle();
    @(negedge clk);
    check("load_retire", {valid_out, dmem_req}, {1'b1, 1'b0});
    tick();
    @(negedge clk);
    check("load_single_pulse", valid_out, 1'b0);

    // STORE: ack in the first WAIT cycle, latency 2
    drive(1'b1, 2'b00, 3'b001, 5'd2, 32'h2000, 32'hCAFE0001);
    exp_q.push_back({2'b00, 5'd2, 32'h2000, 32'h0});
    @(negedge clk);
    check("store_accept_stall", stall_out, 1'b1);
    tick();
    idle();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h12345678;
    @(negedge clk);
    check("store_req", {dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_out},
          {1'b1, 1'b1, 32'h2000, 32'hCAFE0001, 1'b0});
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("store_latency", valid_out, 1'b1);
    tick();

    // Read+write together behaves as a write; Branch bit ignored
    drive(1'b1, 2'b11, 3'b111, 5'd12, 32'h47, 32'hA5A5A5A5);
    exp_q.push_back({2'b11, 5'd12, 32'h47, 32'h0});
    tick();
    idle();
    @(negedge clk);
    check("rw_req", {dmem_we, dmem_addr, dmem_wdata, stall_out},
          {1'b1, 32'h44, 32'hA5A5A5A5, 1'b1});
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h55555555;
    tick();
    dmem_ack = 1'b0;
    tick();
    @(negedge clk);
    check("rw_bubble_hold", {valid_out, WB_out, RD_out, ALU_out, ReadData_out},
          {1'b0, 2'b00, 5'd12, 32'h47, 32'h0});
    tick();

    // Reset two cycles into WAIT discards the access
    drive(1'b1, 2'b11, 3'b010, 5'd9, 32'h300, 32'h0);
    tick();
    idle();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_wait_stall", stall_out, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_drop", {dmem_req, valid_out, WB_out}, 71'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h99999999;
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("rst_late_ack", {valid_out, dmem_req, stall_out}, 71'd0);
    tick();

    // Back-to-back: load, then add held upstream retires the next cycle
    drive(1'b1, 2'b11, 3'b010, 5'd3, 32'h10, 32'h0);
    exp_q.push_back({2'b11, 5'd3, 32'h10, 32'h11112222});
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h11112222;
    @(negedge clk);
    check("b2b_ack_stall", stall_out, 1'b0);
    tick();
    dmem_ack = 1'b0;
    drive(1'b1, 2'b10, 3'b000, 5'd4, 32'h99, 32'h0);
    exp_q.push_back({2'b10, 5'd4, 32'h99, 32'h0});
    @(negedge clk);
    check("b2b_load_valid", {valid_out, stall_out}, {1'b1, 1'b0});
    tick();
    idle();
    @(negedge clk);
    check("b2b_add_valid", valid_out, 1'b1);
    tick();
    @(negedge clk);
    check("b2b_no_dup", valid_out, 1'b0);

`ifdef MEMORY_STAGE_TIMEOUT_EN
    // Timeout: no ack, abort after the count reaches 4
    tick();
    drive(1'b1, 2'b11, 3'b010, 5'd6, 32'h40, 32'h0);
    exp_q.push_back({2'b01, 5'd6, 32'h40, 32'h0});
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("to_wait", {timeout_err, dmem_req}, {1'b0, 1'b1});
      tick();
    end
    @(negedge clk);
    check("to_abort", {timeout_err, valid_out, WB_out[1], dmem_req}, {1'b1, 1'b1, 1'b0, 1'b0});
    tick();
    @(negedge clk);
    check("to_pulse", timeout_err, 1'b0);

    // Ack exactly at count 4 wins
    drive(1'b1, 2'b11, 3'b010, 5'd6, 32'h40, 32'h0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h77;
    exp_q.push_back({2'b11, 5'd6, 32'h40, 32'h77});
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("to_ack_wins", {timeout_err, valid_out}, {1'b0, 1'b1});
    tick();
`endif

    tick();
    check("scoreboard_empty", 71'(exp_q.size()), 71'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
